sha_rx_loader: RTL and testbench

Frames bytes from the UART receiver into one padded SHA-256 message block and streams it to the hash core as sixteen 32-bit words. It sits between `uart_rx` (byte/strobe output) and the SHA-256 core's word-input port. It handles framing, buffering, SHA-256 padding, inter-byte timeout and error reporting, so the hash core sees only complete, correctly padded 512-bit blocks.

---
 rtl/sha_rx_loader.sv | 174 +++++++++++++++++
 tb/tb_sha_rx_loader.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sha_rx_loader.sv
// sha_rx_loader: frames UART bytes (sync, length, data) into one SHA-256
// message block, pads it on the fly and streams it out as 16 big-endian
// words with a valid/ready handshake. Reports bad length, inter-byte
// timeout and overrun as one-cycle error pulses.
module sha_rx_loader #(
    parameter logic [7:0] SYNC_BYTE    = 8'hA5,
    parameter int         TIMEOUT_CLKS = 34720
) (
    input  logic        i_Clock,
    input  logic        i_Reset,
    input  logic        i_Rx_DV,
    input  logic [7:0]  i_Rx_Byte,
    output logic [31:0] o_Word,
    output logic        o_Word_Valid,
    input  logic        i_Word_Ready,
    output logic        o_Word_Last,
    output logic        o_Busy,
    output logic        o_Err,
    output logic [1:0]  o_Err_Code
);

    localparam int TW = $clog2(TIMEOUT_CLKS + 1);

    localparam logic [1:0] ERR_LEN     = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;
    localparam logic [1:0] ERR_OVERRUN = 2'b11;

    typedef enum logic [1:0] {S_IDLE, S_LEN, S_DATA, S_SEND} state_t;

    state_t          state;
    logic [7:0]      msg_buf [0:55];
    logic [5:0]      len;
    logic [5:0]      cnt;
    logic [3:0]      widx;
    logic [TW-1:0]   tmo;
    logic            tmo_hit;
    logic [8:0]      bit_len;
    logic [31:0]     blk_word;
    logic [5:0]      bi;
    logic [7:0]      bv;

    // A strobe in the same cycle as the limit wins over the timeout.
    assign tmo_hit = (tmo == TW'(TIMEOUT_CLKS - 1)) && !i_Rx_DV;
    assign bit_len = {len, 3'b000};

    // Build the current block word from the buffer plus generated padding;
    // bytes at index >= len are never taken from the buffer, so stale data
    // from a longer earlier frame cannot leak out.
    always_comb begin
        blk_word = '0;
        bi       = '0;
        bv       = '0;
        for (int k = 0; k < 4; k++) begin
            bi = {widx, 2'(k)};
            if (bi < len)
                bv = msg_buf[bi];
            else if (bi == len)
                bv = 8'h80;
            else if (bi == 6'd62)
                bv = {7'b0, bit_len[8]};
            else if (bi == 6'd63)
                bv = bit_len[7:0];
            else
                bv = 8'h00;
            blk_word[8*(3-k) +: 8] = bv;
        end
    end

    // Word output is forced to zero whenever nothing is being offered.
    assign o_Word = o_Word_Valid ? blk_word : 32'h0;

    // Message byte storage; deliberately not cleared between frames.
    always_ff @(posedge i_Clock) begin
        if (state == S_DATA && i_Rx_DV)
            msg_buf[cnt] <= i_Rx_Byte;
    end

    // Framing FSM, timeout counter, word sequencing and error reporting.
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            state        <= S_IDLE;
            len          <= '0;
            cnt          <= '0;
            widx         <= '0;
            tmo          <= '0;
            o_Word_Valid <= 1'b0;
            o_Word_Last  <= 1'b0;
            o_Busy       <= 1'b0;
            o_Err        <= 1'b0;
            o_Err_Code   <= 2'b00;
        end else begin
            o_Err <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (i_Rx_DV && i_Rx_Byte == SYNC_BYTE) begin
                        state  <= S_LEN;
                        o_Busy <= 1'b1;
                        tmo    <= '0;
                    end
                end
                S_LEN: begin
                    if (i_Rx_DV) begin
                        tmo <= '0;
                        if (i_Rx_Byte > 8'd55) begin
                            o_Err      <= 1'b1;
                            o_Err_Code <= ERR_LEN;
                            state      <= S_IDLE;
                            o_Busy     <= 1'b0;
                        end else begin
                            len <= i_Rx_Byte[5:0];
                            cnt <= '0;
                            if (i_Rx_Byte == 8'd0) begin
                                state        <= S_SEND;
                                widx         <= '0;
                                o_Word_Valid <= 1'b1;
                                o_Word_Last  <= 1'b0;
                            end else begin
                                state <= S_DATA;
                            end
                        end
                    end else if (tmo_hit) begin
                        o_Err      <= 1'b1;
                        o_Err_Code <= ERR_TIMEOUT;
                        state      <= S_IDLE;
                        o_Busy     <= 1'b0;
                    end else begin
                        tmo <= tmo + TW'(1);
                    end
                end
                S_DATA: begin
                    if (i_Rx_DV) begin
                        tmo <= '0;
                        cnt <= cnt + 6'd1;
                        if (cnt + 6'd1 == len) begin
                            state        <= S_SEND;
                            widx         <= '0;
                            o_Word_Valid <= 1'b1;
                            o_Word_Last  <= 1'b0;
                        end
                    end else if (tmo_hit) begin
                        o_Err      <= 1'b1;
                        o_Err_Code <= ERR_TIMEOUT;
                        state      <= S_IDLE;
                        o_Busy     <= 1'b0;
                    end else begin
                        tmo <= tmo + TW'(1);
                    end
                end
                S_SEND: begin
                    // Any byte arriving now is dropped, including a sync
                    // byte in the final acceptance cycle.
                    if (i_Rx_DV) begin
                        o_Err      <= 1'b1;
                        o_Err_Code <= ERR_OVERRUN;
                    end
                    if (o_Word_Valid && i_Word_Ready) begin
                        if (widx == 4'd15) begin
                            state        <= S_IDLE;
                            widx         <= '0;
                            o_Word_Valid <= 1'b0;
                            o_Word_Last  <= 1'b0;
                            o_Busy       <= 1'b0;
                        end else begin
                            widx        <= widx + 4'd1;
                            o_Word_Last <= (widx == 4'd14);
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sha_rx_loader.sv
// Self-checking bench for sha_rx_loader: table of known frames, hand
// sequences for error and boundary cases, and random frames checked
// against a padded-block reference model.
module tb_sha_rx_loader;

    localparam int TMO = 300;

    typedef logic [7:0] bq_t [$];

    typedef struct {
        string       name;
        int          n;
        logic [7:0]  b0;
        logic [7:0]  inc;
        int          pct;
        logic [31:0] w0;
        logic [31:0] w13;
        logic [31:0] w15;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rx_dv = 1'b0;
    logic [7:0]  rx_byte = 8'h00;
    logic        rdy = 1'b1;
    logic [31:0] word;
    logic        valid, last, busy, err;
    logic [1:0]  err_code;

    int checks = 0;
    int errors = 0;
    int rdy_pct = 100;
    int fb = 0;

    // monitor state
    logic [31:0] got_w [$];
    logic        got_l [$];
    logic [1:0]  err_q [$];
    int          stall_bad = 0;
    int          valid_cnt = 0;
    logic        pv = 1'b0, pr = 1'b0, pl = 1'b0;
    logic [31:0] pw = 32'h0;

    sha_rx_loader #(.SYNC_BYTE(8'hA5), .TIMEOUT_CLKS(TMO)) dut (
        .i_Clock(clk), .i_Reset(rst), .i_Rx_DV(rx_dv), .i_Rx_Byte(rx_byte),
        .o_Word(word), .o_Word_Valid(valid), .i_Word_Ready(rdy),
        .o_Word_Last(last), .o_Busy(busy), .o_Err(err), .o_Err_Code(err_code)
    );

    always #5 clk = ~clk;

    // random backpressure
    initial forever begin
        @(posedge clk);
        #1;
        rdy = ($urandom_range(99) < rdy_pct);
    end

    // capture transfers and error pulses, flag stall violations
    always @(negedge clk) begin
        if (!rst) begin
            if (pv && !pr && (!valid || word !== pw || last !== pl))
                stall_bad <= stall_bad + 1;
            if (valid && rdy) begin
                got_w.push_back(word);
                got_l.push_back(last);
            end
            if (err) err_q.push_back(err_code);
            if (valid) valid_cnt <= valid_cnt + 1;
        end
        pv <= valid;
        pr <= rdy;
        pw <= word;
        pl <= last;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic send(input logic [7:0] b, input int gap);
        repeat (gap) tick();
        rx_byte = b;
        rx_dv   = 1'b1;
        tick();
        rx_dv   = 1'b0;
    endtask

    // Reference: lay out the 64-byte padded block, then read word k.
    function automatic logic [31:0] model_word(input bq_t m, input int k);
        logic [7:0] blk [64];
        int bits;
        foreach (blk[i]) blk[i] = 8'h00;
        foreach (m[i]) blk[i] = m[i];
        blk[m.size()] = 8'h80;
        bits = m.size() * 8;
        blk[62] = bits[15:8];
        blk[63] = bits[7:0];
        return {blk[4*k], blk[4*k+1], blk[4*k+2], blk[4*k+3]};
    endfunction

    // Send a whole frame, collect 16 words and check them against the model.
    // inject >= 0 strobes an extra byte that many cycles into the send phase.
    task automatic run_frame(input string nm, input bq_t m, input int pct,
                             input int inject, input int maxgap);
        int ebase, sb0, cyc;
        rdy_pct = pct;
        fb      = got_w.size();
        ebase   = err_q.size();
        sb0     = stall_bad;
        chk({nm, " idle_busy"}, busy, 1'b0);
        send(8'hA5, 0);
        chk({nm, " busy_rise"}, busy, 1'b1);
        send(8'(m.size()), $urandom_range(maxgap));
        foreach (m[i]) send(m[i], $urandom_range(maxgap));
        chk({nm, " first_valid"}, valid, 1'b1);
        cyc = 0;
        while (got_w.size() - fb < 16 && cyc < 3000) begin
            if (cyc == inject) begin
                rx_byte = 8'hA5;
                rx_dv   = 1'b1;
            end
            tick();
            rx_dv = 1'b0;
            cyc++;
        end
        chk({nm, " word_count"}, got_w.size() - fb, 16);
        if (got_w.size() - fb >= 16) begin
            for (int i = 0; i < 16; i++) begin
                chk($sformatf("%s word%0d", nm, i), got_w[fb+i], model_word(m, i));
                chk($sformatf("%s last%0d", nm, i), got_l[fb+i], (i == 15));
            end
        end
        chk({nm, " end_valid"}, valid, 1'b0);
        chk({nm, " end_busy"}, busy, 1'b0);
        chk({nm, " end_last"}, last, 1'b0);
        chk({nm, " stall_hold"}, stall_bad - sb0, 0);
        if (inject >= 0) begin
            chk({nm, " overrun_cnt"}, err_q.size() - ebase, 1);
            if (err_q.size() > ebase) chk({nm, " overrun_code"}, err_q[ebase], 2'b11);
        end else begin
            chk({nm, " no_err"}, err_q.size() - ebase, 0);
        end
    endtask

    initial begin
        vec_t tbl [4];
        bq_t  m, abc;
        int   cyc, vc0, ebase, n;

        tbl[0] = '{"abc",   3, 8'h61, 8'h01, 100, 32'h61626380, 32'h0, 32'h00000018};
        tbl[1] = '{"empty", 0, 8'h00, 8'h00, 70,  32'h80000000, 32'h0, 32'h00000000};
        tbl[2] = '{"max55", 55, 8'h41, 8'h00, 100, 32'h41414141, 32'h41414180, 32'h000001B8};
        tbl[3] = '{"abcd",  4, 8'h61, 8'h01, 50,  32'h61626364, 32'h0, 32'h00000020};
        abc = '{8'h61, 8'h62, 8'h63};

        // reset state
        repeat (3) tick();
        chk("rst_valid", valid, 1'b0);
        chk("rst_word", word, 32'h0);
        chk("rst_last", last, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_err", err, 1'b0);
        chk("rst_code", err_code, 2'b00);
        rst = 1'b0;
        repeat (2) tick();

        // non-sync bytes in idle are ignored
        send(8'h12, 0);
        send(8'h37, 0);
        tick();
        chk("idle_ignore_busy", busy, 1'b0);

        // known frames (max55 is followed by abc to catch stale bytes)
        foreach (tbl[t]) begin
            m = {};
            for (int i = 0; i < tbl[t].n; i++) m.push_back(8'(tbl[t].b0 + i * tbl[t].inc));
            run_frame(tbl[t].name, m, tbl[t].pct, -1, 0);
            chk({tbl[t].name, " tbl_w0"}, got_w[fb], tbl[t].w0);
            chk({tbl[t].name, " tbl_w13"}, got_w[fb+13], tbl[t].w13);
            chk({tbl[t].name, " tbl_w15"}, got_w[fb+15], tbl[t].w15);
        end
        run_frame("abc_after_max", abc, 100, -1, 0);

        // bad length
        vc0 = valid_cnt;
        send(8'hA5, 0);
        send(8'h38, 0);
        chk("badlen_err", err, 1'b1);
        chk("badlen_code", err_code, 2'b01);
        chk("badlen_busy", busy, 1'b0);
        tick();
        chk("badlen_pulse", err, 1'b0);
        chk("badlen_code_hold", err_code, 2'b01);
        repeat (3) tick();
        chk("badlen_novalid", valid_cnt - vc0, 0);
        run_frame("abc_after_badlen", abc, 100, -1, 0);

        // inter-byte timeout
        send(8'hA5, 0);
        send(8'h03, 0);
        send(8'h61, 0);
        cyc = 0;
        while (!err && cyc < TMO + 50) begin
            tick();
            cyc++;
        end
        chk("tmo_cycles", cyc, TMO);
        chk("tmo_code", err_code, 2'b10);
        chk("tmo_busy", busy, 1'b0);
        vc0 = valid_cnt;
        send(8'h62, 2);
        send(8'h63, 0);
        repeat (3) tick();
        chk("tmo_late_busy", busy, 1'b0);
        chk("tmo_late_novalid", valid_cnt - vc0, 0);

        // overrun during send with backpressure
        run_frame("overrun", abc, 60, 5, 0);

        // sync byte in the word-15 acceptance cycle is an overrun
        rdy_pct = 100;
        repeat (2) tick();
        fb = got_w.size();
        ebase = err_q.size();
        send(8'hA5, 0);
        send(8'h03, 0);
        foreach (abc[i]) send(abc[i], 0);
        repeat (15) tick();
        rx_byte = 8'hA5;
        rx_dv   = 1'b1;
        tick();
        rx_dv   = 1'b0;
        chk("acc15_err", err, 1'b1);
        chk("acc15_code", err_code, 2'b11);
        chk("acc15_busy", busy, 1'b0);
        chk("acc15_valid", valid, 1'b0);
        chk("acc15_words", got_w.size() - fb, 16);
        if (got_w.size() - fb >= 16) chk("acc15_w15", got_w[fb+15], 32'h00000018);
        send(8'h03, 0);
        send(8'h61, 0);
        tick();
        chk("acc15_not_frame", busy, 1'b0);

        // reset while word 7 is presented
        fb = got_w.size();
        send(8'hA5, 0);
        send(8'h03, 0);
        foreach (abc[i]) send(abc[i], 0);
        repeat (7) tick();
        chk("midrst_pre_count", got_w.size() - fb, 7);
        chk("midrst_pre_word", word, 32'h0);
        rst = 1'b1;
        tick();
        chk("midrst_valid", valid, 1'b0);
        chk("midrst_word", word, 32'h0);
        chk("midrst_last", last, 1'b0);
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_err", err, 1'b0);
        chk("midrst_code", err_code, 2'b00);
        rst = 1'b0;
        tick();
        run_frame("abc_after_rst", abc, 100, -1, 0);

        // random frames against the model
        for (int r = 0; r < 10; r++) begin
            m = {};
            n = (r == 0) ? 55 : $urandom_range(55);
            for (int i = 0; i < n; i++) m.push_back(8'($urandom_range(255)));
            run_frame($sformatf("rand%0d", r), m, $urandom_range(30, 100), -1, 3);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
